// File: rtl/uart_regs_pkg.sv
// UART register map shared by the stream bridge and the UART wrapper.
// Latency: n/a (constants only).
// Backpressure: n/a.
package uart_regs_pkg;

  localparam logic [31:0] REG_RX_DATA = 32'h0000_0000;
  localparam logic [31:0] REG_TX_DATA = 32'h0000_0004;
  localparam logic [31:0] REG_PR      = 32'h0000_0008;
  localparam logic [31:0] REG_CTRL    = 32'h0000_000C;
  localparam logic [31:0] REG_CFG     = 32'h0000_0010;
  localparam logic [31:0] REG_RX_STAT = 32'h0000_FE00;
  localparam logic [31:0] REG_TX_STAT = 32'h0000_FE10;

  // CTRL value: bit0 en, bit1 tx_en, bit2 rx_en
  localparam logic [31:0] CTRL_EN     = 32'h0000_0007;

endpackage

// File: rtl/wb_master_port.sv
// Single-outstanding Wishbone classic master port: issues one transaction per start.
// Latency: cyc rises the cycle after start; done/timeout are combinational on the ack/expiry cycle.
// Backpressure: start is only honoured while idle; the owner must wait for done or timeout.
module wb_master_port #(
  parameter int unsigned ACK_TMO = 255
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        start,
  input  logic        start_we,
  input  logic [31:0] start_adr,
  input  logic [31:0] start_dat,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  input  logic        ack_i,
  input  logic [31:0] dat_i,
  output logic        done,
  output logic        timeout,
  output logic [31:0] rdata
);

  localparam logic [7:0] TMO = 8'(ACK_TMO);

  logic [7:0] cnt;

  assign stb_o   = cyc_o;
  assign sel_o   = 4'hF;
  // ack outside a bus cycle is meaningless and must not complete anything
  assign done    = cyc_o & ack_i;
  assign timeout = cyc_o & ~ack_i & (cnt == TMO);
  assign rdata   = dat_i;

  // Launch a transaction, hold it stable, and end it on ack or on wait expiry
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      cyc_o <= 1'b0;
      we_o  <= 1'b0;
      adr_o <= '0;
      dat_o <= '0;
      cnt   <= '0;
    end else if (cyc_o) begin
      if (done || timeout) begin
        cyc_o <= 1'b0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end else if (start) begin
      cyc_o <= 1'b1;
      we_o  <= start_we;
      adr_o <= start_adr;
      dat_o <= start_dat;
      cnt   <= '0;
    end
  end

endmodule

// File: rtl/uart_wb_stream_bridge.sv
// Bridges byte streams to a Wishbone-attached UART: init writes, then alternating RX/TX polling.
// Latency: each byte costs a status read plus a data access (>= 2 cycles each, one idle cycle between).
// Backpressure: RX reads stop while m_valid is held; TX bytes are taken only when the UART FIFO has room.
module uart_wb_stream_bridge
  import uart_regs_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h0000_0000,
  parameter logic [15:0] PRESCALE   = 16'd0,
  parameter logic [31:0] CFG        = 32'h0000_0008,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ACK_TMO    = 255
) (
  input  logic        clk,
  input  logic        rst_i,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  output logic [31:0] adr_o,
  output logic [31:0] dat_o,
  output logic [3:0]  sel_o,
  input  logic        ack_i,
  input  logic [31:0] dat_i,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        init_done,
  output logic        err
);

  typedef enum logic [2:0] {
    ST_INIT_PR, ST_INIT_CFG, ST_INIT_CTRL, ST_POLL_RX,
    ST_READ_RX, ST_POLL_TX, ST_WRITE_TX, ST_ERROR
  } state_t;

  state_t      state, next_state;
  logic        issued;
  logic        start, start_we;
  logic [31:0] start_adr, start_dat;
  logic        done, timeout;
  logic [31:0] rdata;

  wb_master_port #(.ACK_TMO(ACK_TMO)) u_port (
    .clk(clk), .rst_i(rst_i),
    .start(start), .start_we(start_we), .start_adr(start_adr), .start_dat(start_dat),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
    .ack_i(ack_i), .dat_i(dat_i),
    .done(done), .timeout(timeout), .rdata(rdata)
  );

  // State register; issued marks that this state's bus transaction is already launched
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state  <= ST_INIT_PR;
      issued <= 1'b0;
    end else begin
      state <= next_state;
      if (done || timeout) issued <= 1'b0;
      else if (start)      issued <= 1'b1;
    end
  end

  // Next state and transaction request for the current state
  always_comb begin
    next_state = state;
    start      = 1'b0;
    start_we   = 1'b0;
    start_adr  = BASE;
    start_dat  = '0;
    s_ready    = 1'b0;
    case (state)
      ST_INIT_PR: begin
        start_we  = 1'b1;
        start_adr = BASE + REG_PR;
        start_dat = {16'h0, PRESCALE};
        start     = ~issued;
        if (done) next_state = ST_INIT_CFG;
      end
      ST_INIT_CFG: begin
        start_we  = 1'b1;
        start_adr = BASE + REG_CFG;
        start_dat = CFG;
        start     = ~issued;
        if (done) next_state = ST_INIT_CTRL;
      end
      ST_INIT_CTRL: begin
        start_we  = 1'b1;
        start_adr = BASE + REG_CTRL;
        start_dat = CTRL_EN;
        start     = ~issued;
        if (done) next_state = ST_POLL_RX;
      end
      ST_POLL_RX: begin
        start_adr = BASE + REG_RX_STAT;
        // a held RX byte forfeits this poll slot to TX
        if (!issued && m_valid) next_state = ST_POLL_TX;
        else begin
          start = ~issued;
          if (done) next_state = (rdata[3:0] != 4'd0) ? ST_READ_RX : ST_POLL_TX;
        end
      end
      ST_READ_RX: begin
        start_adr = BASE + REG_RX_DATA;
        start     = ~issued;
        if (done) next_state = ST_POLL_TX;
      end
      ST_POLL_TX: begin
        start_adr = BASE + REG_TX_STAT;
        if (!issued && !s_valid) next_state = ST_POLL_RX;
        else begin
          start = ~issued;
          if (done) next_state = (rdata < 32'(FIFO_DEPTH - 1)) ? ST_WRITE_TX : ST_POLL_RX;
        end
      end
      ST_WRITE_TX: begin
        start_we  = 1'b1;
        start_adr = BASE + REG_TX_DATA;
        start_dat = {24'h0, s_data};
        // the byte is taken in the launch cycle; the port holds it until ack
        if (!issued) begin
          if (s_valid) begin
            s_ready = 1'b1;
            start   = 1'b1;
          end else begin
            next_state = ST_POLL_RX;
          end
        end
        if (done) next_state = ST_POLL_RX;
      end
      ST_ERROR: next_state = ST_ERROR;
      default:  next_state = ST_ERROR;
    endcase
    if (timeout) next_state = ST_ERROR;
  end

  // RX output register, init completion and sticky error flag
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      m_valid   <= 1'b0;
      m_data    <= '0;
      init_done <= 1'b0;
      err       <= 1'b0;
    end else begin
      if (state == ST_READ_RX && done) begin
        m_valid <= 1'b1;
        m_data  <= rdata[7:0];
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      if (state == ST_INIT_CTRL && done) init_done <= 1'b1;
      if (timeout) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_wb_stream_bridge.sv
// Directed bench for the UART stream bridge with a behavioural UART register model.
// Latency: model acks one cycle after cyc rises unless stalled.
// Backpressure: stream handshakes are driven directly from the stimulus block.
module tb_uart_wb_stream_bridge;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] adr_o, dat_o;
  logic [3:0]  sel_o;
  logic        ack_i;
  logic [31:0] dat_i;
  logic [7:0]  s_data;
  logic        s_valid, s_ready;
  logic [7:0]  m_data;
  logic        m_valid, m_ready;
  logic        init_done, err;

  uart_wb_stream_bridge #(.PRESCALE(16'h1234)) dut (
    .clk(clk), .rst_i(rst_i),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o), .sel_o(sel_o),
    .ack_i(ack_i), .dat_i(dat_i),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .init_done(init_done), .err(err)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [7:0]  rx_q[$];
  logic [63:0] wlog[$];
  logic [7:0]  got[$];
  logic [7:0]  ev[$];
  logic [31:0] tx_level = 0;
  logic        hold_cfg = 1'b0;
  logic        cyc_q = 1'b0;
  int rx_reads = 0, mv_cycles = 0, sr_pulses = 0, bus_starts = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] wl(input int i);
    return (i < wlog.size()) ? wlog[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // UART register model and stream monitors, all on the falling edge
  initial begin
    ack_i = 1'b0;
    dat_i = '0;
    forever begin
      @(negedge clk);
      if (m_valid && m_ready) got.push_back(m_data);
      if (m_valid) mv_cycles++;
      if (s_ready) sr_pulses++;
      if (cyc_o && !cyc_q) bus_starts++;
      cyc_q = cyc_o;
      if (cyc_o && stb_o && !ack_i && !(hold_cfg && adr_o == 32'h10)) begin
        ack_i = 1'b1;
        dat_i = '0;
        if (we_o) begin
          wlog.push_back({adr_o, dat_o});
          if (adr_o == 32'h4) ev.push_back(8'h2);
        end else begin
          case (adr_o)
            32'h0000_FE00: dat_i = 32'(rx_q.size());
            32'h0000_0000: begin
              rx_reads++;
              ev.push_back(8'h1);
              if (rx_q.size() > 0) dat_i = {24'h0, rx_q.pop_front()};
            end
            32'h0000_FE10: dat_i = tx_level;
            default:       dat_i = '0;
          endcase
        end
      end else begin
        ack_i = 1'b0;
        dat_i = '0;
      end
    end
  end

  initial begin
    int adj, last_r;
    rst_i = 1'b1; s_data = 8'h00; s_valid = 1'b0; m_ready = 1'b0;
    step(3);
    // reset values
    check("rst_cyc", {31'h0, cyc_o}, 32'h0);
    check("rst_stb", {31'h0, stb_o}, 32'h0);
    check("rst_we", {31'h0, we_o}, 32'h0);
    check("rst_adr", adr_o, 32'h0);
    check("rst_dat", dat_o, 32'h0);
    check("rst_sel", {28'h0, sel_o}, 32'hF);
    check("rst_flags", {28'h0, m_valid, s_ready, init_done, err}, 32'h0);
    check("rst_mdata", {24'h0, m_data}, 32'h0);

    // init sequence
    rst_i = 1'b0;
    for (int i = 0; i < 100 && !init_done; i++) step(1);
    check("init_done", {31'h0, init_done}, 32'h1);
    check("init_nwr", 32'(wlog.size()), 32'd3);
    check("init_pr_adr", wl(0)[63:32], 32'h8);
    check("init_pr_dat", wl(0)[31:0], 32'h1234);
    check("init_cfg_adr", wl(1)[63:32], 32'h10);
    check("init_cfg_dat", wl(1)[31:0], 32'h8);
    check("init_ctrl_adr", wl(2)[63:32], 32'hC);
    check("init_ctrl_dat", wl(2)[31:0], 32'h7);

    // two RX bytes, sink always ready
    got.delete(); rx_reads = 0; mv_cycles = 0;
    m_ready = 1'b1;
    rx_q.push_back(8'h55); rx_q.push_back(8'hA3);
    for (int i = 0; i < 200 && got.size() < 2; i++) step(1);
    step(5);
    check("rx2_count", 32'(got.size()), 32'd2);
    check("rx2_b0", (got.size() > 0) ? 32'(got[0]) : 32'hFFFF, 32'h55);
    check("rx2_b1", (got.size() > 1) ? 32'(got[1]) : 32'hFFFF, 32'hA3);
    check("rx2_reads", 32'(rx_reads), 32'd2);
    check("rx2_mv_cycles", 32'(mv_cycles), 32'd2);

    // sink stalled: one byte held, no further data reads
    got.delete(); rx_reads = 0;
    m_ready = 1'b0;
    rx_q.push_back(8'h11); rx_q.push_back(8'h22); rx_q.push_back(8'h33);
    step(100);
    check("rxhold_valid", {31'h0, m_valid}, 32'h1);
    check("rxhold_data", {24'h0, m_data}, 32'h11);
    check("rxhold_reads", 32'(rx_reads), 32'd1);
    m_ready = 1'b1;
    for (int i = 0; i < 200 && got.size() < 3; i++) step(1);
    check("rxrel_count", 32'(got.size()), 32'd3);
    check("rxrel_b2", (got.size() > 2) ? 32'(got[2]) : 32'hFFFF, 32'h33);
    check("rxrel_reads", 32'(rx_reads), 32'd3);

    // TX FIFO nearly full, then room
    wlog.delete(); sr_pulses = 0;
    tx_level = 32'd15; s_data = 8'h3C; s_valid = 1'b1;
    step(100);
    check("txfull_nwr", 32'(wlog.size()), 32'd0);
    check("txfull_srdy", 32'(sr_pulses), 32'd0);
    tx_level = 32'd4;
    for (int i = 0; i < 100 && !s_ready; i++) step(1);
    check("tx_srdy_seen", {31'h0, s_ready}, 32'h1);
    step(1);
    s_valid = 1'b0;
    step(30);
    check("tx_nwr", 32'(wlog.size()), 32'd1);
    check("tx_adr", wl(0)[63:32], 32'h4);
    check("tx_dat", wl(0)[31:0], 32'h3C);
    check("tx_srdy_pulses", 32'(sr_pulses), 32'd1);

    // bidirectional traffic: RX reads and TX writes must interleave
    ev.delete(); got.delete();
    tx_level = 32'd0; s_data = 8'h77; s_valid = 1'b1;
    for (int b = 0; b < 5; b++) rx_q.push_back(8'hA0 + 8'(b));
    step(300);
    s_valid = 1'b0;
    step(20);
    last_r = -1;
    for (int i = 0; i < ev.size(); i++) if (ev[i] == 8'h1) last_r = i;
    adj = 0;
    for (int i = 1; i <= last_r; i++) if (ev[i] == ev[i-1]) adj++;
    check("bidir_rx_count", 32'(got.size()), 32'd5);
    check("bidir_rx_last", (got.size() > 4) ? 32'(got[4]) : 32'hFFFF, 32'hA4);
    check("bidir_adjacent", 32'(adj), 32'd0);
    check("bidir_last_r", 32'(last_r >= 8), 32'd1);

    // ack timeout during INIT_CFG
    hold_cfg = 1'b1;
    rst_i = 1'b1;
    step(2);
    wlog.delete();
    rst_i = 1'b0;
    step(150);
    check("tmo_wait_cyc", {31'h0, cyc_o}, 32'h1);
    check("tmo_wait_adr", adr_o, 32'h10);
    check("tmo_wait_err", {31'h0, err}, 32'h0);
    step(200);
    check("tmo_cyc", {31'h0, cyc_o}, 32'h0);
    check("tmo_err", {31'h0, err}, 32'h1);
    check("tmo_init_done", {31'h0, init_done}, 32'h0);
    bus_starts = 0;
    step(50);
    check("tmo_no_bus", 32'(bus_starts), 32'd0);
    check("tmo_err_sticky", {31'h0, err}, 32'h1);

    // reset recovers and restarts at INIT_PR (asynchronous)
    rst_i = 1'b1;
    #1;
    check("rec_rst_err", {31'h0, err}, 32'h0);
    check("rec_rst_cyc", {31'h0, cyc_o}, 32'h0);
    hold_cfg = 1'b0;
    step(2);
    wlog.delete();
    rst_i = 1'b0;
    for (int i = 0; i < 100 && !init_done; i++) step(1);
    check("rec_init_done", {31'h0, init_done}, 32'h1);
    check("rec_first_adr", wl(0)[63:32], 32'h8);
    check("rec_second_adr", wl(1)[63:32], 32'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
